// File: rtl/axi_wr_pad_pkg.sv
// Shared AXI constants and chunk arithmetic for the write-burst padder.
package axi_wr_pad_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Round a beat count up to a whole number of chunks (chunk_beats is a power of two).
   function automatic logic [8:0] round_up_chunks(input logic [8:0] beats,
                                                  input logic [8:0] chunk_beats);
      round_up_chunks = (beats + chunk_beats - 9'd1) & ~(chunk_beats - 9'd1);
   endfunction

endpackage

// File: rtl/axi_wr_pad_if.sv
// AXI4 write-channel bundle (AW, W, B) with master and slave views.
interface axi_wr_pad_if #(
   parameter int ADDRS        = 32,
   parameter int WIDTH        = 32,
   parameter int MASKS        = WIDTH / 8,
   parameter int AXI_ID_WIDTH = 4
);
   logic                    awvalid;
   logic                    awready;
   logic [ADDRS-1:0]        awaddr;
   logic [AXI_ID_WIDTH-1:0] awid;
   logic [7:0]              awlen;
   logic [1:0]              awburst;
   logic                    wvalid;
   logic                    wready;
   logic                    wlast;
   logic [MASKS-1:0]        wstrb;
   logic [WIDTH-1:0]        wdata;
   logic                    bvalid;
   logic                    bready;
   logic [1:0]              bresp;
   logic [AXI_ID_WIDTH-1:0] bid;

   modport master (
      output awvalid, awaddr, awid, awlen, awburst,
      output wvalid, wlast, wstrb, wdata,
      output bready,
      input  awready, wready, bvalid, bresp, bid
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen, awburst,
      input  wvalid, wlast, wstrb, wdata,
      input  bready,
      output awready, wready, bvalid, bresp, bid
   );
endinterface

// File: rtl/axi_pad_calc.sv
// Combinational chunk-alignment arithmetic for one incoming AW request.
module axi_pad_calc
   import axi_wr_pad_pkg::*;
#(
   parameter int ADDRS       = 32,
   parameter int MASKS       = 4,
   parameter int CHUNK_BEATS = 4
) (
   input  logic [ADDRS-1:0] addr,
   input  logic [7:0]       len,
   input  logic [1:0]       burst,
   output logic [8:0]       lead,
   output logic [8:0]       tail,
   output logic [8:0]       padded,
   output logic [ADDRS-1:0] m_addr,
   output logic [7:0]       m_len,
   output logic             reject
);
   localparam int OB = $clog2(MASKS);
   localparam int CB = OB + $clog2(CHUNK_BEATS);
   localparam logic [ADDRS-1:0] CHUNK_MASK = ADDRS'((64'd1 << CB) - 64'd1);

   logic [8:0] total_s;

   // Beats before the payload, rounded burst size, and the aligned request.
   always_comb begin
      lead    = 9'(addr[CB-1:OB]);
      total_s = lead + 9'(len) + 9'd1;
      padded  = round_up_chunks(total_s, 9'(CHUNK_BEATS));
      tail    = padded - total_s;
      m_addr  = addr & ~CHUNK_MASK;
      m_len   = 8'(padded - 9'd1);
      reject  = (burst != BURST_INCR) || (padded > 9'd256);
   end
endmodule

// File: rtl/axi_wr_pad.sv
// Re-issues INCR write bursts as chunk-aligned bursts with zero-strobe padding.
module axi_wr_pad
   import axi_wr_pad_pkg::*;
#(
   parameter int ADDRS        = 32,
   parameter int WIDTH        = 32,
   parameter int MASKS        = WIDTH / 8,
   parameter int AXI_ID_WIDTH = 4,
   parameter int CHUNK_BEATS  = 4
) (
   input logic          clock,
   input logic          reset,
   axi_wr_pad_if.slave  s,
   axi_wr_pad_if.master m
);
   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_LEAD, ST_DATA, ST_TAIL, ST_RESP, ST_DROP, ST_ERR
   } state_t;

   state_t                  state_r, state_s;
   logic                    en_r;
   logic [ADDRS-1:0]        awaddr_r;
   logic [7:0]              awlen_r;
   logic [7:0]              len_r;
   logic [AXI_ID_WIDTH-1:0] id_r;
   logic [8:0]              lead_r, tail_r, padded_r;
   logic [8:0]              beat_r, pay_r;

   logic [8:0]              lead_s, tail_s, padded_s;
   logic [ADDRS-1:0]        maddr_s;
   logic [7:0]              mlen_s;
   logic                    reject_s;
   logic                    aw_fire_s, beat_fire_s, pay_fire_s;
   logic                    last_beat_s, last_pay_s;

   axi_pad_calc #(
      .ADDRS      (ADDRS),
      .MASKS      (MASKS),
      .CHUNK_BEATS(CHUNK_BEATS)
   ) u_calc (
      .addr  (s.awaddr),
      .len   (s.awlen),
      .burst (s.awburst),
      .lead  (lead_s),
      .tail  (tail_s),
      .padded(padded_s),
      .m_addr(maddr_s),
      .m_len (mlen_s),
      .reject(reject_s)
   );

   // State register; en_r holds s.awready low until the cycle after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         en_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         en_r    <= 1'b1;
      end
   end

   // Capture the legalised request on AW fire and count output/payload beats.
   always_ff @(posedge clock) begin
      if (reset) begin
         awaddr_r <= {ADDRS{1'b0}};
         awlen_r  <= 8'd0;
         len_r    <= 8'd0;
         id_r     <= {AXI_ID_WIDTH{1'b0}};
         lead_r   <= 9'd0;
         tail_r   <= 9'd0;
         padded_r <= 9'd0;
         beat_r   <= 9'd0;
         pay_r    <= 9'd0;
      end else if (aw_fire_s) begin
         awaddr_r <= maddr_s;
         awlen_r  <= mlen_s;
         len_r    <= s.awlen;
         id_r     <= s.awid;
         lead_r   <= lead_s;
         tail_r   <= tail_s;
         padded_r <= padded_s;
         beat_r   <= 9'd0;
         pay_r    <= 9'd0;
      end else begin
         if (beat_fire_s) beat_r <= beat_r + 9'd1;
         if (pay_fire_s)  pay_r  <= pay_r + 9'd1;
      end
   end

   // Next state and all channel outputs, including the zero-latency W/B relay.
   always_comb begin
      state_s     = state_r;
      aw_fire_s   = 1'b0;
      beat_fire_s = 1'b0;
      pay_fire_s  = 1'b0;
      last_beat_s = (beat_r == (padded_r - 9'd1));
      last_pay_s  = (pay_r == 9'(len_r));
      s.awready   = 1'b0;
      s.wready    = 1'b0;
      s.bvalid    = 1'b0;
      s.bresp     = RESP_OKAY;
      s.bid       = id_r;
      m.awvalid   = 1'b0;
      m.awaddr    = awaddr_r;
      m.awid      = id_r;
      m.awlen     = awlen_r;
      m.awburst   = BURST_INCR;
      m.wvalid    = 1'b0;
      m.wlast     = 1'b0;
      m.wstrb     = {MASKS{1'b0}};
      m.wdata     = {WIDTH{1'b0}};
      m.bready    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            s.awready = en_r;
            if (s.awvalid && en_r) begin
               aw_fire_s = 1'b1;
               state_s   = reject_s ? ST_DROP : ST_ADDR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            m.awvalid = 1'b1;
            if (m.awready) begin
               state_s = (lead_r == 9'd0) ? ST_DATA : ST_LEAD;
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_LEAD: begin
            m.wvalid = 1'b1;
            m.wlast  = last_beat_s;
            if (m.wready) begin
               beat_fire_s = 1'b1;
               state_s     = (beat_r == (lead_r - 9'd1)) ? ST_DATA : ST_LEAD;
            end else begin
               state_s = ST_LEAD;
            end
         end
         ST_DATA: begin
            m.wvalid = s.wvalid;
            s.wready = m.wready;
            m.wdata  = s.wdata;
            m.wstrb  = s.wstrb;
            m.wlast  = last_beat_s;
            if (s.wvalid && m.wready) begin
               beat_fire_s = 1'b1;
               pay_fire_s  = 1'b1;
               if (last_pay_s) begin
                  state_s = (tail_r == 9'd0) ? ST_RESP : ST_TAIL;
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_TAIL: begin
            m.wvalid = 1'b1;
            m.wlast  = last_beat_s;
            if (m.wready) begin
               beat_fire_s = 1'b1;
               state_s     = last_beat_s ? ST_RESP : ST_TAIL;
            end else begin
               state_s = ST_TAIL;
            end
         end
         ST_RESP: begin
            m.bready = s.bready;
            s.bvalid = m.bvalid;
            s.bresp  = m.bresp;
            if (m.bvalid && s.bready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         ST_DROP: begin
            s.wready = 1'b1;
            if (s.wvalid) begin
               pay_fire_s = 1'b1;
               state_s    = last_pay_s ? ST_ERR : ST_DROP;
            end else begin
               state_s = ST_DROP;
            end
         end
         ST_ERR: begin
            s.bvalid = 1'b1;
            s.bresp  = RESP_SLVERR;
            if (s.bready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_ERR;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_axi_wr_pad.sv
// Randomised bench for axi_wr_pad against a queue-based model of the padded burst.
module tb_axi_wr_pad;
   import axi_wr_pad_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   axi_wr_pad_if #(.ADDRS(32), .WIDTH(32), .MASKS(4), .AXI_ID_WIDTH(4)) s_bus ();
   axi_wr_pad_if #(.ADDRS(32), .WIDTH(32), .MASKS(4), .AXI_ID_WIDTH(4)) m_bus ();

   axi_wr_pad #(.ADDRS(32), .WIDTH(32), .MASKS(4), .AXI_ID_WIDTH(4), .CHUNK_BEATS(4)) dut (
      .clock(clock),
      .reset(reset),
      .s    (s_bus.slave),
      .m    (m_bus.master)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pay_data_q[$];
   logic [3:0]  pay_strb_q[$];
   logic [31:0] exp_data_q[$];
   logic [3:0]  exp_strb_q[$];
   logic [31:0] seen_awaddr;
   logic [7:0]  seen_awlen;
   int          aw_seen;
   bit          w_done;
   bit          b_got;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [3:0] id, input bit gaps, input int bdly);
      int lead, total, padded;
      bit rej;
      logic [1:0] mresp;
      lead   = int'(addr[3:2]);
      total  = lead + len + 1;
      padded = ((total + 3) / 4) * 4;
      rej    = (burst != 2'b01) || (padded > 256);
      mresp  = 2'($urandom_range(0, 3));
      pay_data_q.delete(); pay_strb_q.delete();
      exp_data_q.delete(); exp_strb_q.delete();
      for (int i = 0; i <= len; i++) begin
         pay_data_q.push_back($urandom);
         pay_strb_q.push_back(4'($urandom_range(1, 15)));
      end
      for (int i = 0; i < padded; i++) begin
         if (i >= lead && i < lead + len + 1) begin
            exp_data_q.push_back(pay_data_q[i - lead]);
            exp_strb_q.push_back(pay_strb_q[i - lead]);
         end else begin
            exp_data_q.push_back(32'd0);
            exp_strb_q.push_back(4'd0);
         end
      end
      aw_seen = 0; w_done = 1'b0; b_got = 1'b0;
      @(posedge clock); #1;
      fork
         begin : up_aw
            int t;
            t = 0;
            s_bus.awvalid = 1'b1; s_bus.awaddr = addr; s_bus.awlen = 8'(len);
            s_bus.awburst = burst; s_bus.awid = id;
            do begin @(negedge clock); t++; end while (!s_bus.awready && t < 200);
            if (t >= 200) chk("aw_in_timeout", 64'd0, 64'd1);
            @(posedge clock); #1;
            s_bus.awvalid = 1'b0;
         end
         begin : up_w
            int t;
            for (int i = 0; i <= len; i++) begin
               t = 0;
               if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
               s_bus.wvalid = 1'b1; s_bus.wdata = pay_data_q[i]; s_bus.wstrb = pay_strb_q[i];
               s_bus.wlast = (i == len);
               do begin @(negedge clock); t++; end while (!s_bus.wready && t < 2000);
               @(posedge clock); #1;
               s_bus.wvalid = 1'b0;
               if (t >= 2000) begin
                  chk("w_in_timeout", 64'(i), 64'(len));
                  break;
               end
            end
         end
         begin : dn_aw
            int t;
            t = 0;
            if (!rej) begin
               while (t < 200 && aw_seen == 0) begin
                  @(posedge clock); #1;
                  m_bus.awready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                  @(negedge clock); t++;
                  if (m_bus.awvalid && m_bus.awready) begin
                     aw_seen++;
                     seen_awaddr = m_bus.awaddr; seen_awlen = m_bus.awlen;
                     chk("m_awaddr", m_bus.awaddr, {addr[31:4], 4'h0});
                     chk("m_awlen", m_bus.awlen, 64'(padded - 1));
                     chk("m_awburst", m_bus.awburst, 64'd1);
                     chk("m_awid", m_bus.awid, id);
                  end
               end
               @(posedge clock); #1;
               m_bus.awready = 1'b0;
               if (aw_seen == 0) chk("m_aw_timeout", 64'd0, 64'd1);
            end else begin
               while (!b_got && t < 4000) begin
                  @(negedge clock); t++;
                  chk("rej_no_awvalid", m_bus.awvalid, 64'd0);
                  chk("rej_no_wvalid", m_bus.wvalid, 64'd0);
               end
            end
         end
         begin : dn_w
            int k, t;
            k = 0; t = 0;
            if (!rej) begin
               while (k < padded && t < 4000) begin
                  @(posedge clock); #1;
                  m_bus.wready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                  @(negedge clock); t++;
                  if (m_bus.wvalid && m_bus.wready) begin
                     chk("w_data", m_bus.wdata, exp_data_q[k]);
                     chk("w_strb", m_bus.wstrb, exp_strb_q[k]);
                     chk("w_last", m_bus.wlast, 64'(k == padded - 1));
                     k++;
                  end
               end
               @(posedge clock); #1;
               m_bus.wready = 1'b0;
               if (k < padded) chk("w_out_timeout", 64'(k), 64'(padded));
               w_done = 1'b1;
            end
         end
         begin : dn_b
            int t;
            t = 0;
            if (!rej) begin
               while (!w_done && t < 5000) begin @(negedge clock); t++; end
               repeat (bdly) @(posedge clock);
               @(posedge clock); #1;
               m_bus.bvalid = 1'b1; m_bus.bresp = mresp; m_bus.bid = ~id;
               t = 0;
               do begin @(negedge clock); t++; end while (!m_bus.bready && t < 200);
               if (t >= 200) chk("m_b_timeout", 64'd0, 64'd1);
               @(posedge clock); #1;
               m_bus.bvalid = 1'b0;
            end
         end
         begin : up_b
            int t;
            t = 0;
            while (!b_got && t < 8000) begin
               @(posedge clock); #1;
               s_bus.bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
               @(negedge clock); t++;
               if (s_bus.bvalid && s_bus.bready) begin
                  b_got = 1'b1;
                  chk("b_resp", s_bus.bresp, rej ? 64'd2 : 64'(mresp));
                  chk("b_id", s_bus.bid, id);
                  if (!rej) chk("b_after_w", 64'(w_done), 64'd1);
               end
            end
            @(posedge clock); #1;
            s_bus.bready = 1'b0;
            if (!b_got) chk("b_timeout", 64'd0, 64'd1);
            @(negedge clock);
            chk("b_single", s_bus.bvalid, 64'd0);
         end
      join
      chk("aw_count", 64'(aw_seen), rej ? 64'd0 : 64'd1);
      @(negedge clock);
      chk("idle_wvalid", m_bus.wvalid, 64'd0);
      chk("idle_awready", s_bus.awready, 64'd1);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t;
      s_bus.awvalid = 1'b0; s_bus.awaddr = 32'd0; s_bus.awid = 4'd0; s_bus.awlen = 8'd0;
      s_bus.awburst = 2'b01; s_bus.wvalid = 1'b0; s_bus.wlast = 1'b0; s_bus.wstrb = 4'd0;
      s_bus.wdata = 32'd0; s_bus.bready = 1'b0;
      m_bus.awready = 1'b0; m_bus.wready = 1'b0; m_bus.bvalid = 1'b0;
      m_bus.bresp = 2'b00; m_bus.bid = 4'd0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_awready", s_bus.awready, 64'd0);
      chk("rst_m_awvalid", m_bus.awvalid, 64'd0);
      chk("rst_m_wvalid", m_bus.wvalid, 64'd0);
      chk("rst_m_wlast", m_bus.wlast, 64'd0);
      chk("rst_m_wstrb", m_bus.wstrb, 64'd0);
      chk("rst_s_bvalid", s_bus.bvalid, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("awready_after_rst_0", s_bus.awready, 64'd0);
      @(negedge clock);
      chk("awready_after_rst_1", s_bus.awready, 64'd1);

      run_burst(32'h100, 3, 2'b01, 4'd5, 1'b0, 0);
      chk("t1_awaddr", seen_awaddr, 64'h100);
      chk("t1_awlen", seen_awlen, 64'd3);
      run_burst(32'h104, 0, 2'b01, 4'd6, 1'b0, 1);
      chk("t2_awaddr", seen_awaddr, 64'h100);
      chk("t2_awlen", seen_awlen, 64'd3);
      run_burst(32'h10C, 4, 2'b01, 4'd7, 1'b0, 0);
      chk("t3_awlen", seen_awlen, 64'd7);
      run_burst(32'h108, 255, 2'b01, 4'd8, 1'b0, 0);
      run_burst(32'h100, 3, 2'b00, 4'd9, 1'b0, 0);
      run_burst(32'h200, 255, 2'b01, 4'd10, 1'b0, 0);
      chk("len255_awlen", seen_awlen, 64'd255);
      run_burst(32'h304, 9, 2'b01, 4'd11, 1'b1, 10);

      for (int n = 0; n < 16; n++) begin
         logic [31:0] a;
         int          l;
         logic [1:0]  b;
         a = {20'h0, 10'($urandom), 2'b00};
         l = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 12);
         b = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         run_burst(a, l, b, 4'($urandom), 1'b1, $urandom_range(0, 10));
      end

      // Reset in the middle of a payload phase, then a clean burst.
      @(posedge clock); #1;
      s_bus.awvalid = 1'b1; s_bus.awaddr = 32'h200; s_bus.awlen = 8'd7;
      s_bus.awburst = 2'b01; s_bus.awid = 4'd3;
      t = 0;
      do begin @(negedge clock); t++; end while (!s_bus.awready && t < 50);
      if (t >= 50) chk("t6_aw_timeout", 64'd0, 64'd1);
      @(posedge clock); #1;
      s_bus.awvalid = 1'b0;
      m_bus.awready = 1'b1; m_bus.wready = 1'b1;
      s_bus.wvalid = 1'b1; s_bus.wdata = 32'hA5A5_0001; s_bus.wstrb = 4'hF;
      repeat (4) @(posedge clock);
      @(negedge clock);
      chk("t6_in_data", m_bus.wvalid, 64'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      s_bus.wvalid = 1'b0; m_bus.awready = 1'b0; m_bus.wready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("t6_m_awvalid", m_bus.awvalid, 64'd0);
      chk("t6_m_wvalid", m_bus.wvalid, 64'd0);
      chk("t6_m_wlast", m_bus.wlast, 64'd0);
      chk("t6_m_wstrb", m_bus.wstrb, 64'd0);
      chk("t6_s_bvalid", s_bus.bvalid, 64'd0);
      chk("t6_s_awready", s_bus.awready, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      run_burst(32'h208, 5, 2'b01, 4'd12, 1'b1, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
